// File: rtl/pattern_detect_ctrl_if.sv
// Bundles the serial stream, configuration handshake and match-event stream of
// pattern_detect_ctrl; master drives the requests, slave is the controller side.
interface pattern_detect_ctrl_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             x;
    logic             x_vld;
    logic             z;
    logic             cfg_vld;
    logic             cfg_rdy;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             evt_vld;
    logic             evt_rdy;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic             ovr;
    logic             clr_cnt;

    modport master (
        output x, x_vld, cfg_vld, cfg_pat, cfg_len, cfg_ovl, evt_rdy, clr_cnt,
        input  z, cfg_rdy, evt_vld, evt_cnt, match_cnt, ovr
    );

    modport slave (
        input  x, x_vld, cfg_vld, cfg_pat, cfg_len, cfg_ovl, evt_rdy, clr_cnt,
        output z, cfg_rdy, evt_vld, evt_cnt, match_cnt, ovr
    );
endinterface

// File: rtl/pattern_detect_ctrl.sv
// Programmable Mealy serial pattern detector with overlap control, saturating
// match counter and a handshaked match-event stream with sticky overrun flag.
module pattern_detect_ctrl #(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 16,
    parameter logic [PAT_W-1:0] DEF_PAT = 8'h79,
    parameter int               DEF_LEN = 7,
    parameter bit               DEF_OVL = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    pattern_detect_ctrl_if.slave io_bus
);
    localparam int               LEN_W   = $clog2(PAT_W) + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {ST_RUN, ST_FLUSH} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [CNT_W-1:0] r_cnt;
    logic             r_evt_vld;
    logic [CNT_W-1:0] r_evt_cnt;
    logic             r_ovr;

    logic             w_run;
    logic             w_cfg_acc;
    logic [LEN_W-1:0] w_cfg_len;
    logic [PAT_W-1:0] w_win;
    logic [PAT_W-1:0] w_mask;
    logic             w_match;
    logic [LEN_W-1:0] w_fill_inc;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_evt_take;

    // FSM: RUN accepts config, FLUSH is a single cycle that discards history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_run = 1'b1;
                if (io_bus.cfg_vld) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    assign io_bus.cfg_rdy = w_run;
    assign w_cfg_acc      = w_run & io_bus.cfg_vld;

    always_comb begin
        w_cfg_len = io_bus.cfg_len;
        if (io_bus.cfg_len == '0) begin
            w_cfg_len = LEN_W'(1);
        end else if (io_bus.cfg_len > LEN_MAX) begin
            w_cfg_len = LEN_MAX;
        end
    end

    // Only the low r_len bits of the window take part in the compare.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
            assign w_mask[gi] = (LEN_W'(gi) < r_len);
        end
    endgenerate

    assign w_win   = {r_hist[PAT_W-2:0], io_bus.x};
    assign w_match = w_run & io_bus.x_vld
                   & (r_fill >= (r_len - LEN_W'(1)))
                   & ((w_win & w_mask) == (r_pat & w_mask));
    assign io_bus.z = w_match & i_rst_n;

    assign w_fill_inc = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);

    always_comb begin
        w_cnt_next = r_cnt;
        if (io_bus.clr_cnt) begin
            w_cnt_next = '0;
        end else if (w_match && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    assign w_evt_take = ~r_evt_vld | io_bus.evt_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pat <= DEF_PAT;
            r_len <= LEN_W'(DEF_LEN);
            r_ovl <= DEF_OVL;
        end else if (w_cfg_acc) begin
            r_pat <= io_bus.cfg_pat;
            r_len <= w_cfg_len;
            r_ovl <= io_bus.cfg_ovl;
        end
    end

    // A non-overlapping match restarts the history so the next match needs len fresh bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_run && io_bus.x_vld) begin
            if (w_match && !r_ovl) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_win;
                r_fill <= w_fill_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_evt_vld <= 1'b0;
            r_evt_cnt <= '0;
            r_ovr     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (io_bus.clr_cnt) begin
                r_ovr <= 1'b0;
            end else if (w_match && !w_evt_take) begin
                r_ovr <= 1'b1;
            end
            if (w_match) begin
                if (w_evt_take) begin
                    r_evt_vld <= 1'b1;
                    r_evt_cnt <= w_cnt_next;
                end
            end else if (r_evt_vld && io_bus.evt_rdy) begin
                r_evt_vld <= 1'b0;
            end
        end
    end

    assign io_bus.match_cnt = r_cnt;
    assign io_bus.evt_vld   = r_evt_vld;
    assign io_bus.evt_cnt   = r_evt_cnt;
    assign io_bus.ovr       = r_ovr;
endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed self-checking bench for pattern_detect_ctrl: default detector, config
// and overlap modes, backpressure, saturation (4-bit counter), gaps and mid-stream reset.
module tb_pattern_detect_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pattern_detect_ctrl_if #(.PAT_W(8), .CNT_W(16)) mif ();
    pattern_detect_ctrl_if #(.PAT_W(8), .CNT_W(4))  sif ();

    pattern_detect_ctrl #(.PAT_W(8), .CNT_W(16)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (mif)
    );

    pattern_detect_ctrl #(.PAT_W(8), .CNT_W(4)) u_sat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached before completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic send_bit(input logic b, input logic v, output logic zo);
        @(negedge clk);
        mif.x     = b;
        mif.x_vld = v;
        #1;
        zo = mif.z;
    endtask

    // Sends n bits MSB first; zv[i] records z for the i-th sample (0-based).
    task automatic send_stream(input logic [31:0] bits, input int n, output logic [31:0] zv);
        logic zo;
        zv = '0;
        for (int i = 0; i < n; i++) begin
            send_bit(bits[n-1-i], 1'b1, zo);
            zv[i] = zo;
        end
        @(negedge clk);
        mif.x_vld = 1'b0;
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        @(negedge clk);
        mif.x_vld   = 1'b0;
        mif.cfg_pat = pat;
        mif.cfg_len = len;
        mif.cfg_ovl = ovl;
        mif.cfg_vld = 1'b1;
        #1;
        check_val("cfg_rdy_accept", 32'(mif.cfg_rdy), 32'd1);
        @(negedge clk);
        mif.cfg_vld = 1'b0;
        #1;
        check_val("cfg_rdy_flush", 32'(mif.cfg_rdy), 32'd0);
        @(negedge clk);
        #1;
        check_val("cfg_rdy_back", 32'(mif.cfg_rdy), 32'd1);
    endtask

    task automatic do_clr();
        @(negedge clk);
        mif.clr_cnt = 1'b1;
        @(negedge clk);
        mif.clr_cnt = 1'b0;
        #1;
    endtask

    logic [31:0] zv;
    logic [31:0] zbits;
    logic        zo;
    logic        gapz;

    initial begin
        rst_n       = 1'b0;
        mif.x       = 1'b0;
        mif.x_vld   = 1'b0;
        mif.cfg_vld = 1'b0;
        mif.cfg_pat = '0;
        mif.cfg_len = '0;
        mif.cfg_ovl = 1'b0;
        mif.evt_rdy = 1'b1;
        mif.clr_cnt = 1'b0;
        sif.x       = 1'b0;
        sif.x_vld   = 1'b0;
        sif.cfg_vld = 1'b0;
        sif.cfg_pat = '0;
        sif.cfg_len = '0;
        sif.cfg_ovl = 1'b1;
        sif.evt_rdy = 1'b1;
        sif.clr_cnt = 1'b0;

        // Reset state
        #12;
        check_val("rst_match_cnt", 32'(mif.match_cnt), 32'd0);
        check_val("rst_evt_vld", 32'(mif.evt_vld), 32'd0);
        check_val("rst_ovr", 32'(mif.ovr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_cfg_rdy", 32'(mif.cfg_rdy), 32'd1);

        // Default overlapping 1111001
        send_stream(32'h1E79, 13, zv);
        check_val("dflt_z_vec", zv, 32'h1040);
        check_val("dflt_match_cnt", 32'(mif.match_cnt), 32'd2);
        check_val("dflt_evt_cnt", 32'(mif.evt_cnt), 32'd2);
        check_val("dflt_evt_vld", 32'(mif.evt_vld), 32'd1);
        check_val("dflt_ovr", 32'(mif.ovr), 32'd0);

        // Pattern 101, non-overlapping then overlapping
        do_cfg(8'h05, 4'd3, 1'b0);
        do_clr();
        send_stream(32'h15, 5, zv);
        check_val("novl_z_vec", zv, 32'h04);
        check_val("novl_match_cnt", 32'(mif.match_cnt), 32'd1);
        do_cfg(8'h05, 4'd3, 1'b1);
        do_clr();
        send_stream(32'h15, 5, zv);
        check_val("ovl_z_vec", zv, 32'h14);
        check_val("ovl_match_cnt", 32'(mif.match_cnt), 32'd2);

        // Backpressure on the event stream
        do_cfg(8'h79, 4'd7, 1'b1);
        do_clr();
        mif.evt_rdy = 1'b0;
        send_stream(32'h1E79, 13, zv);
        check_val("bp_z_vec", zv, 32'h1040);
        check_val("bp_evt_vld", 32'(mif.evt_vld), 32'd1);
        check_val("bp_evt_cnt", 32'(mif.evt_cnt), 32'd1);
        check_val("bp_ovr", 32'(mif.ovr), 32'd1);
        check_val("bp_match_cnt", 32'(mif.match_cnt), 32'd2);
        mif.evt_rdy = 1'b1;
        @(negedge clk);
        #1;
        check_val("bp_evt_vld_drain", 32'(mif.evt_vld), 32'd0);
        check_val("bp_ovr_sticky", 32'(mif.ovr), 32'd1);
        do_clr();
        check_val("bp_clr_match_cnt", 32'(mif.match_cnt), 32'd0);
        check_val("bp_clr_ovr", 32'(mif.ovr), 32'd0);

        // Saturation on the 4-bit counter instance
        @(negedge clk);
        sif.cfg_pat = 8'h01;
        sif.cfg_len = 4'd1;
        sif.cfg_ovl = 1'b1;
        sif.cfg_vld = 1'b1;
        @(negedge clk);
        sif.cfg_vld = 1'b0;
        @(negedge clk);
        zv = '0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            sif.x     = 1'b1;
            sif.x_vld = 1'b1;
            #1;
            zv[i] = sif.z;
        end
        @(negedge clk);
        sif.x_vld = 1'b0;
        #1;
        check_val("sat_z_vec", zv, 32'h1FFFF);
        check_val("sat_match_cnt", 32'(sif.match_cnt), 32'd15);
        @(negedge clk);
        sif.x_vld   = 1'b1;
        sif.clr_cnt = 1'b1;
        #1;
        check_val("sat_clr_z", 32'(sif.z), 32'd1);
        @(negedge clk);
        sif.x_vld   = 1'b0;
        sif.clr_cnt = 1'b0;
        #1;
        check_val("sat_clr_match_cnt", 32'(sif.match_cnt), 32'd0);
        check_val("sat_clr_evt_cnt", 32'(sif.evt_cnt), 32'd0);

        // Gaps with random x while x_vld is low
        do_clr();
        zbits = '0;
        gapz  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            logic [6:0] pat;
            pat = 7'b1111001;
            send_bit(pat[6-i], 1'b1, zo);
            zbits[i] = zo;
            for (int g = 0; g < 1 + (i % 2); g++) begin
                send_bit(1'($urandom_range(1, 0)), 1'b0, zo);
                gapz = gapz | zo;
            end
        end
        @(negedge clk);
        #1;
        check_val("gap_z_vec", zbits, 32'h40);
        check_val("gap_no_z", 32'(gapz), 32'd0);
        check_val("gap_match_cnt", 32'(mif.match_cnt), 32'd1);

        // Reset mid-stream discards the partial 11110
        do_clr();
        send_stream(32'h1E, 5, zv);
        check_val("rmid_pre_z", zv, 32'h0);
        @(negedge clk);
        rst_n     = 1'b0;
        mif.x     = 1'b1;
        mif.x_vld = 1'b1;
        #1;
        check_val("rmid_z", 32'(mif.z), 32'd0);
        check_val("rmid_match_cnt", 32'(mif.match_cnt), 32'd0);
        check_val("rmid_evt_vld", 32'(mif.evt_vld), 32'd0);
        check_val("rmid_evt_cnt", 32'(mif.evt_cnt), 32'd0);
        check_val("rmid_ovr", 32'(mif.ovr), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mif.x_vld = 1'b0;
        #1;
        check_val("rmid_cfg_rdy", 32'(mif.cfg_rdy), 32'd1);
        send_stream(32'h1, 2, zv);
        check_val("rmid_post_z", zv, 32'h0);
        send_stream(32'h79, 7, zv);
        check_val("rmid_full_z_vec", zv, 32'h40);
        check_val("rmid_full_match_cnt", 32'(mif.match_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
